// File: rtl/bin_to_bcd_display_feed.sv
// bin_to_bcd_display_feed: sequential double-dabble converter feeding a packed
// 8-digit BCD word and a sticky enable to the seven-segment display controller.
`default_nettype none

module bin_to_bcd_display_feed #(
    parameter int WIDTH   = 27,
    parameter int MAX_VAL = 99_999_999
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic [31:0]      bcd_out,
    output logic             valid_out,
    output logic             overflow_out,
    output logic             en_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] MAX_VAL_W  = 32'(MAX_VAL);
    localparam logic [4:0]  LAST_SHIFT = 5'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shift_reg;
    logic [31:0]        scratch;
    logic [31:0]        scratch_adj;
    logic [4:0]         shift_cnt;
    logic               saturate;
    logic [31:0]        bin_ext;

    assign bin_ext = 32'(bin_in);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_out = 1'b0;
        busy_out  = 1'b1;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                busy_out  = 1'b0;
                if (valid_in) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (shift_cnt == LAST_SHIFT) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every digit that would exceed 9 after the next shift.
    always_comb begin
        scratch_adj = scratch;
        for (int k = 0; k < 8; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shift_reg    <= '0;
            scratch      <= '0;
            shift_cnt    <= '0;
            saturate     <= 1'b0;
            bcd_out      <= '0;
            valid_out    <= 1'b0;
            overflow_out <= 1'b0;
            en_out       <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        shift_cnt <= '0;
                        saturate  <= (bin_ext > MAX_VAL_W);
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
                    shift_cnt            <= shift_cnt + 5'd1;
                end
                DONE: begin
                    // Only the finished word reaches the display; scratch is never exposed.
                    bcd_out      <= saturate ? 32'h9999_9999 : scratch;
                    overflow_out <= saturate;
                    valid_out    <= 1'b1;
                    en_out       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_display_feed.sv
// Scoreboard bench for bin_to_bcd_display_feed: stimulus pushes expected words,
// a negedge monitor pops and compares on every valid_out pulse.
`default_nettype none

module tb_bin_to_bcd_display_feed;

    localparam int WIDTH = 27;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] bin = '0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic             busy_out;
    logic [31:0]      bcd_out;
    logic             valid_out;
    logic             overflow_out;
    logic             en_out;

    bin_to_bcd_display_feed #(.WIDTH(WIDTH), .MAX_VAL(99_999_999)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .bin_in      (bin),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .busy_out    (busy_out),
        .bcd_out     (bcd_out),
        .valid_out   (valid_out),
        .overflow_out(overflow_out),
        .en_out      (en_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          edge_n;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_bcd = '0;
    logic        last_ovf = 1'b0;
    logic        exp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_bcd", bcd_out, 32'h0);
            check("rst_valid", {31'b0, valid_out}, 32'h0);
            check("rst_en", {31'b0, en_out}, 32'h0);
            check("rst_ready", {31'b0, ready_out}, 32'h1);
            last_bcd = '0;
            last_ovf = 1'b0;
            exp_en   = 1'b0;
            q.delete();
        end else begin
            check("ready_busy_compl", {31'b0, ready_out ^ busy_out}, 32'h1);
            if (valid_out) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: bcd_out=%h with nothing pending (cycle %0d)", bcd_out, cyc);
                end else begin
                    e = q.pop_front();
                    check("bcd", bcd_out, e.bcd);
                    check("ovf", {31'b0, overflow_out}, {31'b0, e.ovf});
                    check("latency", 32'(cyc - e.edge_n), 32'(LAT));
                    check("en_on_valid", {31'b0, en_out}, 32'h1);
                    last_bcd = e.bcd;
                    last_ovf = e.ovf;
                    exp_en   = 1'b1;
                end
            end else begin
                check("hold_bcd", bcd_out, last_bcd);
                check("hold_ovf", {31'b0, overflow_out}, {31'b0, last_ovf});
                check("en_state", {31'b0, en_out}, {31'b0, exp_en});
            end
        end
    end

    task automatic push_exp(input logic [31:0] bcd, input logic ovf, input int edge_n);
        exp_t t;
        t.bcd    = bcd;
        t.ovf    = ovf;
        t.edge_n = edge_n;
        q.push_back(t);
    endtask

    task automatic issue(input logic [WIDTH-1:0] v, input logic [31:0] bcd, input logic ovf);
        @(negedge clk);
        bin      = v;
        valid_in = 1'b1;
        check("ready_at_accept", {31'b0, ready_out}, 32'h1);
        @(posedge clk);
        #1;
        push_exp(bcd, ovf, cyc);
        valid_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending after %0d cycles", q.size(), budget);
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Idle after reset: nothing may be produced.
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("idle_en", {31'b0, en_out}, 32'h0);
        check("idle_bcd", bcd_out, 32'h0);
        check("idle_ready", {31'b0, ready_out}, 32'h1);

        issue(27'd0, 32'h0000_0000, 1'b0);            drain(60);
        issue(27'd12_345_678, 32'h1234_5678, 1'b0);   drain(60);
        issue(27'd99_999_999, 32'h9999_9999, 1'b0);   drain(60);
        issue(27'd100_000_000, 32'h9999_9999, 1'b1);  drain(60);
        issue(27'd134_217_727, 32'h9999_9999, 1'b1);  drain(60);
        issue(27'd7, 32'h0000_0007, 1'b0);            drain(60);

        // valid_in held high; a bin_in change while busy must be ignored.
        @(negedge clk);
        bin      = 27'd42;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        push_exp(32'h0000_0042, 1'b0, e0);
        repeat (5) @(posedge clk);
        bin = 27'd55;
        push_exp(32'h0000_0055, 1'b0, e0 + 29);
        repeat (24) @(posedge clk);
        #1;
        valid_in = 1'b0;
        drain(80);

        // A one-cycle request while busy is dropped.
        issue(27'd321, 32'h0000_0321, 1'b0);
        repeat (10) @(negedge clk);
        bin      = 27'd777;
        valid_in = 1'b1;
        @(negedge clk) valid_in = 1'b0;
        drain(60);
        repeat (40) @(posedge clk);

        // Asynchronous reset mid-conversion aborts it.
        issue(27'd42, 32'h0000_0042, 1'b0);           drain(60);
        @(negedge clk);
        bin      = 27'd12_345_678;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_bcd", bcd_out, 32'h0);
        check("async_rst_en", {31'b0, en_out}, 32'h0);
        check("async_rst_ready", {31'b0, ready_out}, 32'h1);
        check("async_rst_busy", {31'b0, busy_out}, 32'h0);
        check("async_rst_valid", {31'b0, valid_out}, 32'h0);
        check("async_rst_ovf", {31'b0, overflow_out}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        issue(27'd999, 32'h0000_0999, 1'b0);          drain(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
